fetch_unit: RTL and testbench

//   RV32I instruction fetch front end; producer of the 32-bit `ins` word consumed by the decoder.

---
 rtl/fetch_unit.sv | 163 ++++++++++++++++
 tb/tb_fetch_unit.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: RV32I instruction fetch front end.
//   Owns the PC, issues word reads to instruction memory, buffers returned
//   words in a DEPTH-entry FIFO and presents {ins, ins_pc} to decode.
//   A redirect from execute flushes the FIFO, drops in-flight responses and
//   restarts fetch at redirect_pc; a misaligned target halts fetch.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   imem_req/addr/ready        request channel (word address, bits [1:0] = 0)
//   imem_rvalid/rdata          in-order read response channel
//   ins_valid/ins/ins_pc       FIFO head towards decode
//   ins_ready                  decode consumes head
//   redirect/redirect_pc       taken jump/branch from execute
//   fetch_fault                misaligned redirect target, fetch halted
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        ins_valid,
    output logic [31:0] ins,
    output logic [31:0] ins_pc,
    input  logic        ins_ready,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        fetch_fault
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    localparam logic [0:0] ST_RUN  = 1'b0;
    localparam logic [0:0] ST_HALT = 1'b1;

    logic [0:0]    state_q, state_d;
    logic [31:0]   pc_q, pc_d;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] inflight_q, inflight_d;
    logic [CW-1:0] drop_q, drop_d;
    logic [PW-1:0] fifo_rd_q, fifo_rd_d;
    logic [PW-1:0] fifo_wr_q, fifo_wr_d;
    logic [PW-1:0] aq_rd_q, aq_rd_d;
    logic [PW-1:0] aq_wr_q, aq_wr_d;

    logic [31:0] fifo_ins_q [DEPTH];
    logic [31:0] fifo_pc_q  [DEPTH];
    logic [31:0] aq_pc_q    [DEPTH];

    logic        accept;
    logic        resp;
    logic        keep;
    logic        pop;
    logic        credit_ok;
    logic [CW:0] occupancy;

    // Credit check: buffered words plus outstanding requests (including those
    // still to be dropped) never exceed the FIFO depth, so a push never overflows.
    assign occupancy = {1'b0, count_q} + {1'b0, inflight_q};
    assign credit_ok = occupancy < (CW+1)'(DEPTH);

    // Request issue; gated by rst_n so the memory sees no request during reset.
    assign imem_req  = rst_n && (state_q == ST_RUN) && !redirect && credit_ok;
    assign imem_addr = pc_q;
    assign accept    = imem_req && imem_ready;

    // A response with nothing outstanding belongs to a pre-reset request.
    assign resp = imem_rvalid && (inflight_q != '0);
    // Response written to the FIFO: not owed to a drop, not killed by redirect.
    assign keep = resp && (drop_q == '0) && !redirect;

    // FIFO head towards decode.
    assign ins_valid   = (count_q != '0);
    assign ins         = fifo_ins_q[fifo_rd_q];
    assign ins_pc      = fifo_pc_q[fifo_rd_q];
    assign pop         = ins_valid && ins_ready && !redirect;
    assign fetch_fault = (state_q == ST_HALT);

    // Next-state logic for PC, counters, pointers and run/halt state.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        count_d    = count_q;
        inflight_d = inflight_q;
        drop_d     = drop_q;
        fifo_rd_d  = fifo_rd_q;
        fifo_wr_d  = fifo_wr_q;
        aq_rd_d    = aq_rd_q;
        aq_wr_d    = aq_wr_q;

        if (redirect) begin
            // Everything still outstanding after this edge is discarded on return.
            state_d    = (redirect_pc[1:0] != 2'b00) ? ST_HALT : ST_RUN;
            pc_d       = redirect_pc;
            count_d    = '0;
            fifo_rd_d  = '0;
            fifo_wr_d  = '0;
            aq_rd_d    = '0;
            aq_wr_d    = '0;
            inflight_d = inflight_q - CW'(resp);
            drop_d     = inflight_q - CW'(resp);
        end else begin
            if (accept) begin
                pc_d    = pc_q + 32'd4;
                aq_wr_d = aq_wr_q + PW'(1);
            end
            inflight_d = inflight_q + CW'(accept) - CW'(resp);
            if (resp && (drop_q != '0)) begin
                drop_d = drop_q - CW'(1);
            end
            if (keep) begin
                fifo_wr_d = fifo_wr_q + PW'(1);
                aq_rd_d   = aq_rd_q + PW'(1);
            end
            if (pop) begin
                fifo_rd_d = fifo_rd_q + PW'(1);
            end
            count_d = count_q + CW'(keep) - CW'(pop);
        end
    end

    // State and storage registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_RUN;
            pc_q       <= RESET_PC;
            count_q    <= '0;
            inflight_q <= '0;
            drop_q     <= '0;
            fifo_rd_q  <= '0;
            fifo_wr_q  <= '0;
            aq_rd_q    <= '0;
            aq_wr_q    <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                fifo_ins_q[i] <= '0;
                fifo_pc_q[i]  <= '0;
                aq_pc_q[i]    <= '0;
            end
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            count_q    <= count_d;
            inflight_q <= inflight_d;
            drop_q     <= drop_d;
            fifo_rd_q  <= fifo_rd_d;
            fifo_wr_q  <= fifo_wr_d;
            aq_rd_q    <= aq_rd_d;
            aq_wr_q    <= aq_wr_d;
            if (keep) begin
                fifo_ins_q[fifo_wr_q] <= imem_rdata;
                fifo_pc_q[fifo_wr_q]  <= aq_pc_q[aq_rd_q];
            end
            if (accept) begin
                aq_pc_q[aq_wr_q] <= pc_q;
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed self-checking bench for fetch_unit.
//   dut  : RESET_PC = 0, driven by a 1-cycle-latency memory that can be paused.
//   dut2 : RESET_PC = FFFF_FFF8, free-running, used for PC wrap.
module tb_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        ins_valid;
    logic [31:0] ins;
    logic [31:0] ins_pc;
    logic        ins_ready;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        fetch_fault;

    logic        req2;
    logic [31:0] addr2;
    logic        rvalid2;
    logic [31:0] rdata2;
    logic        ins_valid2;
    logic [31:0] ins2;
    logic [31:0] ins_pc2;
    logic        fault2;
    logic        pend2;
    logic [31:0] paddr2;

    logic        mem_en;
    logic [31:0] mq[$];
    logic [31:0] iss[$];
    logic [31:0] iss2[$];
    logic [31:0] got_ins[$];
    logic [31:0] got_pc[$];

    int total;
    int bad;

    fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .ins_valid(ins_valid), .ins(ins), .ins_pc(ins_pc), .ins_ready(ins_ready),
        .redirect(redirect), .redirect_pc(redirect_pc), .fetch_fault(fetch_fault)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(2)) dut2 (
        .clk(clk), .rst_n(rst_n),
        .imem_req(req2), .imem_addr(addr2), .imem_ready(1'b1),
        .imem_rvalid(rvalid2), .imem_rdata(rdata2),
        .ins_valid(ins_valid2), .ins(ins2), .ins_pc(ins_pc2), .ins_ready(1'b1),
        .redirect(1'b0), .redirect_pc(32'h0), .fetch_fault(fault2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] word(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    // Memory model and logging: responses presented 1 after negedge,
    // accepts/consumes recorded 2 after negedge (inputs settled, before posedge).
    always begin
        @(negedge clk);
        #1;
        if (!rst_n) begin
            mq.delete();
            imem_rvalid = 1'b0;
            rvalid2     = 1'b0;
            pend2       = 1'b0;
        end else begin
            if (mem_en && mq.size() > 0) begin
                imem_rvalid = 1'b1;
                imem_rdata  = word(mq.pop_front());
            end else begin
                imem_rvalid = 1'b0;
            end
            rvalid2 = pend2;
            rdata2  = word(paddr2);
        end
        #1;
        if (imem_req && imem_ready) begin
            mq.push_back(imem_addr);
            iss.push_back(imem_addr);
        end
        if (ins_valid && ins_ready && !redirect) begin
            got_ins.push_back(ins);
            got_pc.push_back(ins_pc);
        end
        pend2  = req2;
        paddr2 = addr2;
        if (req2 && iss2.size() < 3) iss2.push_back(addr2);
    end

    task automatic clear_logs();
        iss.delete();
        got_ins.delete();
        got_pc.delete();
    endtask

    // One-cycle redirect pulse driven on a negedge.
    task automatic do_redirect(input logic [31:0] target);
        @(negedge clk);
        redirect    = 1'b1;
        redirect_pc = target;
        #3;
        clear_logs();
        @(negedge clk);
        redirect = 1'b0;
    endtask

    // Halt fetch via a misaligned target and let in-flight responses drain.
    task automatic quiesce();
        mem_en = 1'b1;
        do_redirect(32'h0000_0001);
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL reset_req: got %b want 0", imem_req); end
        total++; if (ins_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", ins_valid); end
        total++; if (fetch_fault !== 1'b0) begin bad++; $display("FAIL reset_fault: got %b want 0", fetch_fault); end
        clear_logs();
        rst_n = 1'b1;
    endtask

    task automatic test_stream();
        repeat (20) @(negedge clk);
        total++; if (iss.size() < 10) begin bad++; $display("FAIL stream_iss_cnt: got %0d want >=10", iss.size()); end
        for (int i = 0; i < iss.size(); i++) begin
            total++;
            if (iss[i] !== 32'(i * 4)) begin bad++; $display("FAIL stream_addr[%0d]: got %h want %h", i, iss[i], 32'(i * 4)); end
        end
        total++; if (got_pc.size() < 8) begin bad++; $display("FAIL stream_ins_cnt: got %0d want >=8", got_pc.size()); end
        for (int i = 0; i < got_pc.size(); i++) begin
            total++;
            if (got_pc[i] !== 32'(i * 4) || got_ins[i] !== word(32'(i * 4))) begin
                bad++; $display("FAIL stream_ins[%0d]: got pc=%h ins=%h want pc=%h ins=%h",
                                i, got_pc[i], got_ins[i], 32'(i * 4), word(32'(i * 4)));
            end
        end
    endtask

    task automatic test_stall();
        @(negedge clk);
        ins_ready   = 1'b0;
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0040;
        #3;
        clear_logs();
        @(negedge clk);
        redirect = 1'b0;
        repeat (10) @(negedge clk);
        total++; if (iss.size() != 2) begin bad++; $display("FAIL stall_iss_cnt: got %0d want 2", iss.size()); end
        total++; if (iss.size() < 2 || iss[0] !== 32'h40 || iss[1] !== 32'h44) begin bad++; $display("FAIL stall_addrs: got %0d entries want 40,44", iss.size()); end
        total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL stall_req: got %b want 0", imem_req); end
        total++; if (ins_valid !== 1'b1 || ins_pc !== 32'h40 || ins !== word(32'h40)) begin
            bad++; $display("FAIL stall_head: got v=%b pc=%h ins=%h want v=1 pc=40 ins=%h", ins_valid, ins_pc, ins, word(32'h40));
        end
        ins_ready = 1'b1;
        repeat (20) @(negedge clk);
        total++; if (got_pc.size() < 8) begin bad++; $display("FAIL resume_cnt: got %0d want >=8", got_pc.size()); end
        for (int i = 0; i < got_pc.size(); i++) begin
            total++;
            if (got_pc[i] !== 32'h40 + 32'(i * 4) || got_ins[i] !== word(32'h40 + 32'(i * 4))) begin
                bad++; $display("FAIL resume_ins[%0d]: got pc=%h ins=%h want pc=%h", i, got_pc[i], got_ins[i], 32'h40 + 32'(i * 4));
            end
        end
        for (int i = 0; i < iss.size(); i++) begin
            total++;
            if (iss[i] !== 32'h40 + 32'(i * 4)) begin bad++; $display("FAIL resume_addr[%0d]: got %h want %h", i, iss[i], 32'h40 + 32'(i * 4)); end
        end
    endtask

    task automatic test_redirect_inflight();
        quiesce();
        mem_en = 1'b0;
        do_redirect(32'h0000_0010);
        repeat (4) @(negedge clk);
        total++; if (iss.size() != 2 || iss[0] !== 32'h10 || iss[1] !== 32'h14) begin bad++; $display("FAIL inflight_addrs: got %0d entries want 10,14", iss.size()); end
        total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL inflight_req: got %b want 0", imem_req); end
        total++; if (ins_valid !== 1'b0) begin bad++; $display("FAIL inflight_valid: got %b want 0", ins_valid); end
        do_redirect(32'h0000_0100);
        mem_en = 1'b1;
        repeat (10) @(negedge clk);
        total++; if (got_pc.size() < 2) begin bad++; $display("FAIL redir_cnt: got %0d want >=2", got_pc.size()); end
        else begin
            total++; if (got_pc[0] !== 32'h100 || got_ins[0] !== word(32'h100)) begin bad++; $display("FAIL redir_first: got pc=%h ins=%h want pc=100 ins=%h", got_pc[0], got_ins[0], word(32'h100)); end
            total++; if (got_pc[1] !== 32'h104) begin bad++; $display("FAIL redir_second: got pc=%h want 104", got_pc[1]); end
        end
    endtask

    task automatic test_redirect_same_cycle();
        quiesce();
        mem_en = 1'b0;
        do_redirect(32'h0000_0020);
        repeat (4) @(negedge clk);
        total++; if (iss.size() != 2 || iss[0] !== 32'h20 || iss[1] !== 32'h24) begin bad++; $display("FAIL same_addrs: got %0d entries want 20,24", iss.size()); end
        @(negedge clk);
        mem_en      = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0300;
        #3;
        clear_logs();
        @(negedge clk);
        redirect = 1'b0;
        total++; if (ins_valid !== 1'b0) begin bad++; $display("FAIL same_valid: got %b want 0", ins_valid); end
        repeat (10) @(negedge clk);
        total++; if (got_pc.size() < 1) begin bad++; $display("FAIL same_cnt: got %0d want >=1", got_pc.size()); end
        else if (got_pc[0] !== 32'h300 || got_ins[0] !== word(32'h300)) begin
            bad++; $display("FAIL same_first: got pc=%h ins=%h want pc=300 ins=%h", got_pc[0], got_ins[0], word(32'h300));
        end
    endtask

    task automatic test_fault();
        mem_en = 1'b1;
        do_redirect(32'h0000_0102);
        total++; if (fetch_fault !== 1'b1) begin bad++; $display("FAIL fault_set: got %b want 1", fetch_fault); end
        total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL fault_req: got %b want 0", imem_req); end
        repeat (4) @(negedge clk);
        total++; if (imem_req !== 1'b0 || ins_valid !== 1'b0 || fetch_fault !== 1'b1) begin
            bad++; $display("FAIL fault_hold: got req=%b v=%b fault=%b want 0 0 1", imem_req, ins_valid, fetch_fault);
        end
        do_redirect(32'h0000_0200);
        total++; if (fetch_fault !== 1'b0) begin bad++; $display("FAIL fault_clear: got %b want 0", fetch_fault); end
        repeat (8) @(negedge clk);
        total++; if (iss.size() < 1 || iss[0] !== 32'h200) begin bad++; $display("FAIL fault_resume_addr: got %0d entries want first 200", iss.size()); end
        total++; if (got_pc.size() < 1 || got_pc[0] !== 32'h200 || got_ins[0] !== word(32'h200)) begin
            bad++; $display("FAIL fault_resume_ins: got %0d entries want first pc 200", got_pc.size());
        end
    endtask

    task automatic test_wrap();
        total++; if (iss2.size() != 3) begin bad++; $display("FAIL wrap_cnt: got %0d want 3", iss2.size()); end
        else begin
            total++; if (iss2[0] !== 32'hFFFF_FFF8) begin bad++; $display("FAIL wrap_a0: got %h want fffffff8", iss2[0]); end
            total++; if (iss2[1] !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_a1: got %h want fffffffc", iss2[1]); end
            total++; if (iss2[2] !== 32'h0000_0000) begin bad++; $display("FAIL wrap_a2: got %h want 00000000", iss2[2]); end
        end
    endtask

    task automatic test_reset_mid();
        do_redirect(32'h0000_0080);
        repeat (6) @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL rmid_req: got %b want 0", imem_req); end
        total++; if (ins_valid !== 1'b0) begin bad++; $display("FAIL rmid_valid: got %b want 0", ins_valid); end
        total++; if (fetch_fault !== 1'b0) begin bad++; $display("FAIL rmid_fault: got %b want 0", fetch_fault); end
        clear_logs();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        total++; if (iss.size() < 1 || iss[0] !== 32'h0) begin bad++; $display("FAIL rmid_addr: got %0d entries want first 0", iss.size()); end
        total++; if (got_pc.size() < 2 || got_pc[0] !== 32'h0 || got_ins[0] !== word(32'h0) || got_pc[1] !== 32'h4) begin
            bad++; $display("FAIL rmid_ins: got %0d entries want pcs 0,4", got_pc.size());
        end
    endtask

    initial begin
        total       = 0;
        bad         = 0;
        rst_n       = 1'b0;
        imem_ready  = 1'b1;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        ins_ready   = 1'b1;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        mem_en      = 1'b1;
        rvalid2     = 1'b0;
        rdata2      = 32'h0;
        pend2       = 1'b0;
        paddr2      = 32'h0;

        test_reset();
        test_stream();
        test_stall();
        test_redirect_inflight();
        test_redirect_same_cycle();
        test_fault();
        test_wrap();
        test_reset_mid();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
